// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module : spi_pkg
// Brief  : Shared types and default parameters for the SPI initiator
//          (spi_master_tx) and its sclk divider (spi_sclk_gen).
// Contents:
//   spi_tx_state_e   frame sequencer states
//   SPI_DATA_W_DEF   default bits per frame
//   SPI_CLK_DIV_DEF  default clk cycles per sclk half-period
// Rev    : 1.0  initial release
// ============================================================================
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEAD    = 3'd1,
    SHIFT   = 3'd2,
    HOLD_CS = 3'd3,
    GAP     = 3'd4
  } spi_tx_state_e;

  localparam int SPI_DATA_W_DEF  = 12;
  localparam int SPI_CLK_DIV_DEF = 4;

endpackage
`default_nettype wire

// File: rtl/spi_sclk_gen.sv
`default_nettype none
// ============================================================================
// Module : spi_sclk_gen
// Brief  : Half-period divider for sclk. A tick counter runs 0..CLK_DIV-1
//          while enabled; each wrap produces a strobe, alternating between
//          rise_stb and fall_stb (rise first after every clear).
// Ports  :
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   en        in   counting enable (sequencer not idle)
//   clr       in   restart counter and phase (sequencer state change)
//   rise_stb  out  one-clk strobe: end of a low half-period
//   fall_stb  out  one-clk strobe: end of a high half-period
// Rev    : 1.0  initial release
// ============================================================================
module spi_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] tick;
  logic             phase;   // 0: next wrap is a rise, 1: next wrap is a fall
  logic             wrap;

  assign wrap = (tick == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick  <= '0;
      phase <= 1'b0;
    end else if (!en || clr) begin
      tick  <= '0;
      phase <= 1'b0;
    end else if (wrap) begin
      tick  <= '0;
      phase <= ~phase;
    end else begin
      tick  <= tick + 1'b1;
    end
  end

  assign rise_stb = en && wrap && !phase;
  assign fall_stb = en && wrap &&  phase;

endmodule
`default_nettype wire

// File: rtl/spi_master_tx.sv
`default_nettype none
// ============================================================================
// Module : spi_master_tx
// Brief  : SPI initiator. Serialises a DATA_W-bit word onto cs/sclk/mosi:
//          one lead-in sclk pulse, then DATA_W data bits MSB first, then a
//          cs-low hold half-period and a cs-high gap of two half-periods.
// Config : define SPI_MASTER_TX_HOLD_EN for a one-entry holding register
//          allowing back-to-back frames; ready then means "hold is empty".
// Ports  :
//   clk    in   system clock, posedge
//   rst_n  in   asynchronous active-low reset
//   newd   in   request: din valid, start frame
//   din    in   word to transmit (DATA_W)
//   ready  out  newd will be accepted this cycle
//   done   out  one-clk pulse coincident with cs rising
//   sclk   out  SPI clock, idle low
//   cs     out  chip select, active low
//   mosi   out  serial data, MSB first
// Rev    : 1.0  initial release
// ============================================================================
module spi_master_tx
  import spi_pkg::*;
#(
  parameter int DATA_W  = SPI_DATA_W_DEF,
  parameter int CLK_DIV = SPI_CLK_DIV_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              newd,
  input  logic [DATA_W-1:0] din,
  output logic              ready,
  output logic              done,
  output logic              sclk,
  output logic              cs,
  output logic              mosi
);

  localparam int BCNT_W = $clog2(DATA_W + 1);
  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_W - 1);

  spi_tx_state_e     state;
  spi_tx_state_e     state_nxt;
  logic              rise_stb;
  logic              fall_stb;
  logic [DATA_W-1:0] shift_reg;
  logic [BCNT_W-1:0] bit_cnt;
  logic              capture;     // newd accepted at this edge
  logic              start;       // a frame begins at this edge
  logic [DATA_W-1:0] start_word;  // word loaded when a frame begins
  logic              last_fall;   // falling edge of the final data bit

  assign capture   = newd && ready;
  assign last_fall = (state == SHIFT) && fall_stb && (bit_cnt == LAST_BIT);

`ifdef SPI_MASTER_TX_HOLD_EN
  logic              hold_valid;
  logic [DATA_W-1:0] hold_data;
  logic              start_slot;  // a frame may begin here: idle, or last gap cycle
  logic              from_hold;
  logic              to_hold;

  assign start_slot = (state == IDLE) || ((state == GAP) && fall_stb);
  assign ready      = !hold_valid;
  assign from_hold  = start_slot && hold_valid;
  // A word accepted outside a start slot parks in hold until the gap ends.
  assign to_hold    = capture && !start_slot;
  assign start      = from_hold || (start_slot && capture);
  assign start_word = hold_valid ? hold_data : din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (to_hold) begin
      hold_valid <= 1'b1;
      hold_data  <= din;
    end else if (from_hold) begin
      hold_valid <= 1'b0;
    end
  end
`else
  assign ready      = (state == IDLE);
  assign start      = capture;
  assign start_word = din;
`endif

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (state != IDLE),
    .clr      (state_nxt != state),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)     state_nxt = LEAD;
      LEAD:    if (fall_stb)  state_nxt = SHIFT;
      SHIFT:   if (last_fall) state_nxt = HOLD_CS;
      HOLD_CS: if (rise_stb)  state_nxt = GAP;
      GAP: begin
        if (start)         state_nxt = LEAD;
        else if (fall_stb) state_nxt = IDLE;
      end
      default:                state_nxt = IDLE;
    endcase
  end

  // Pin and datapath registers. The lead-in pulse toggles sclk but leaves
  // mosi alone; in SHIFT every falling edge but the last advances one bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk      <= 1'b0;
      cs        <= 1'b1;
      mosi      <= 1'b0;
      done      <= 1'b0;
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        shift_reg <= start_word;
        bit_cnt   <= '0;
        cs        <= 1'b0;
        mosi      <= start_word[DATA_W-1];
      end else begin
        case (state)
          LEAD: begin
            if (rise_stb)      sclk <= 1'b1;
            else if (fall_stb) sclk <= 1'b0;
          end
          SHIFT: begin
            if (rise_stb) begin
              sclk <= 1'b1;
            end else if (fall_stb) begin
              sclk <= 1'b0;
              if (bit_cnt != LAST_BIT) begin
                shift_reg <= shift_reg << 1;
                mosi      <= shift_reg[DATA_W-2];
                bit_cnt   <= bit_cnt + 1'b1;
              end
            end
          end
          HOLD_CS: begin
            if (rise_stb) begin
              cs   <= 1'b1;
              mosi <= 1'b0;
              done <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_master_tx.sv
`default_nettype none
// ============================================================================
// Module : tb_spi_master_tx
// Brief  : Self-checking bench for spi_master_tx (DATA_W=12, CLK_DIV=4) plus a
//          small DATA_W=2, CLK_DIV=1 instance. A frame-level reference model
//          tracks each accepted word and the cycle offset inside its frame;
//          expected pin levels follow from that offset. A slave decoder
//          rebuilds words from the pins and checks them against a queue.
// Config : honours SPI_MASTER_TX_HOLD_EN (holding-register build).
// Rev    : 1.0  initial release
// ============================================================================
module tb_spi_master_tx;

  localparam int D    = 12;
  localparam int C    = 4;
  localparam int LOWN = (2*D + 3) * C;   // cs-low length
  localparam int P    = (2*D + 5) * C;   // frame start to next start slot
`ifdef SPI_MASTER_TX_HOLD_EN
  localparam bit HOLD_MODE = 1'b1;
`else
  localparam bit HOLD_MODE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         newd = 1'b0;
  logic [D-1:0] din = '0;
  logic         ready, done, sclk, cs, mosi;

  logic         newd2 = 1'b0;
  logic [1:0]   din2 = '0;
  logic         ready2, done2, sclk2, cs2, mosi2;

  always #5 clk = ~clk;

  spi_master_tx #(.DATA_W(D), .CLK_DIV(C)) u_dut (
    .clk(clk), .rst_n(rst_n), .newd(newd), .din(din), .ready(ready),
    .done(done), .sclk(sclk), .cs(cs), .mosi(mosi)
  );

  spi_master_tx #(.DATA_W(2), .CLK_DIV(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .newd(newd2), .din(din2), .ready(ready2),
    .done(done2), .sclk(sclk2), .cs(cs2), .mosi(mosi2)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  int           busy = 0;    // cycles left until the next start slot
  logic [D-1:0] cur = '0;    // word of the frame in flight
  logic         hfull = 1'b0;
  logic [D-1:0] hdata = '0;
  logic [D-1:0] exp_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 0;
      hfull <= 1'b0;
      cur   <= '0;
      exp_q.delete();
    end else begin
      if (HOLD_MODE) begin
        if (busy <= 1 && hfull) begin
          busy  <= P;
          cur   <= hdata;
          hfull <= 1'b0;
        end else if (busy <= 1 && newd) begin
          busy <= P;
          cur  <= din;
          exp_q.push_back(din);
        end else begin
          if (busy > 0) busy <= busy - 1;
          if (newd && !hfull) begin
            hfull <= 1'b1;
            hdata <= din;
            exp_q.push_back(din);
          end
        end
      end else begin
        if (busy == 0 && newd) begin
          busy <= P;
          cur  <= din;
          exp_q.push_back(din);
        end else if (busy > 0) begin
          busy <= busy - 1;
        end
      end
    end
  end

  // Expected {cs, sclk, mosi, done} for a frame at offset P-b from its start.
  function automatic logic [3:0] exp_pins(input int b, input logic [D-1:0] w);
    int o, h, k;
    if (b == 0) return 4'b1000;
    o = P - b;
    h = o / C;
    if (o >= LOWN) return {1'b1, 1'b0, 1'b0, (o == LOWN)};
    k = (h < 4) ? 0 : (h - 2) / 2;
    if (k > D - 1) k = D - 1;
    return {1'b0, (h % 2 == 1), w[D-1-k], 1'b0};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [3:0]   e;
    logic         m_ready;
    logic         prev_low;
    logic         prev_sclk;
    int           low_n;
    int           rises;
    logic [D-1:0] word;
    logic [D-1:0] exp_w;
    prev_low = 1'b0; prev_sclk = 1'b0; low_n = 0; rises = 0; word = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_low  = 1'b0;
        prev_sclk = 1'b0;
      end else begin
        e       = exp_pins(busy, cur);
        m_ready = HOLD_MODE ? !hfull : (busy == 0);
        total++;
        if ({cs, sclk, mosi, done} !== e) begin
          bad++;
          $display("FAIL pins t=%0t got cs/sclk/mosi/done=%b expected %b", $time,
                   {cs, sclk, mosi, done}, e);
        end
        total++;
        if (ready !== m_ready) begin
          bad++;
          $display("FAIL ready t=%0t got %b expected %b", $time, ready, m_ready);
        end
        if (cs === 1'b0) begin
          if (!prev_low) begin
            low_n = 0; rises = 0; word = '0;
          end
          low_n++;
          if (sclk === 1'b1 && !prev_sclk) begin
            rises++;
            if (rises > 1) word = {word[D-2:0], mosi};
          end
          prev_low = 1'b1;
        end else if (prev_low) begin
          prev_low = 1'b0;
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL frame_word got %h expected none (no word queued)", word);
          end else begin
            exp_w = exp_q.pop_front();
            if (word !== exp_w) begin
              bad++;
              $display("FAIL frame_word got %h expected %h", word, exp_w);
            end
          end
          total++;
          if (low_n != LOWN || rises != D + 1) begin
            bad++;
            $display("FAIL frame_shape got low=%0d rises=%0d expected low=%0d rises=%0d",
                     low_n, rises, LOWN, D + 1);
          end
        end
        prev_sclk = (sclk === 1'b1);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [D-1:0] w);
    @(negedge clk);
    newd = 1'b1;
    din  = w;
    @(negedge clk);
    newd = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy != 0 || hfull) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      total++;
      bad++;
      $display("FAIL idle_timeout got busy=%0d expected 0", busy);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_idle(input string name);
    total++;
    if ({cs, sclk, mosi, done, ready} !== 5'b10001) begin
      bad++;
      $display("FAIL %s got cs/sclk/mosi/done/ready=%b expected 10001", name,
               {cs, sclk, mosi, done, ready});
    end
  endtask

  logic [4:0] t6 [10];

  initial begin
    logic [D-1:0] w;
    logic [4:0]   e6;
    t6 = '{5'b00100, 5'b01100, 5'b00100, 5'b01100, 5'b00000,
           5'b01000, 5'b00000, 5'b10010, 5'b10000, 5'b10001};

    repeat (3) @(negedge clk);
    #1 check_idle("reset");
    total++;
    if ({cs2, sclk2, mosi2, done2, ready2} !== 5'b10001) begin
      bad++;
      $display("FAIL reset2 got %b expected 10001", {cs2, sclk2, mosi2, done2, ready2});
    end
    rst_n = 1'b1;

    send(12'hA5C); wait_idle();
    send(12'hFFF); wait_idle();
    send(12'h000); wait_idle();

    // second request 20 cycles into a frame: dropped, or held if enabled
    send(12'h123);
    repeat (19) @(negedge clk);
    send(12'h456);
    wait_idle();

    // asynchronous reset in the middle of a frame
    send(12'h999);
    repeat (49) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_idle("async_reset");
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    send(12'h3C3); wait_idle();

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 80)) @(negedge clk);
      w = D'($urandom());
      send(w);
    end
    wait_idle();

    // minimal configuration: DATA_W=2, CLK_DIV=1, word 2'b10
    @(negedge clk);
    newd2 = 1'b1;
    din2  = 2'b10;
    @(negedge clk);
    newd2 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      e6 = t6[i];
      if (HOLD_MODE) e6[0] = 1'b1;
      total++;
      if ({cs2, sclk2, mosi2, done2, ready2} !== e6) begin
        bad++;
        $display("FAIL small_cfg cycle %0d got cs/sclk/mosi/done/ready=%b expected %b",
                 i, {cs2, sclk2, mosi2, done2, ready2}, e6);
      end
      @(negedge clk);
    end

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_words got %0d expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
